// File: rtl/cdma_pkg.sv
// Shared constants, state encoding and LFSR step helper for the CDMA
// spreading/despreading blocks.
package cdma_pkg;

  localparam int SYM_LEN = 31;

  // Feedback tap masks: the new LSB is the XOR of the masked register bits.
  localparam logic [4:0] TAPS_A = 5'b11110;
  localparam logic [4:0] TAPS_B = 5'b10010;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACQ   = 2'd1,
    ST_TRACK = 2'd2
  } state_t;

  function automatic logic [4:0] lfsr_step(input logic [4:0] s, input logic [4:0] taps);
    return {s[3:0], ^(s & taps)};
  endfunction

endpackage

// File: rtl/gold_gen.sv
// Gold-code chip generator built from two 5-bit LFSRs; shared with the
// transmitter so both ends produce bit-identical sequences.
module gold_gen
  import cdma_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [4:0] seed_i,
  input  logic       adv_i,
  output logic       gold_o
);

  logic [4:0] lfsr_a;
  logic [4:0] lfsr_b;

  // Load wins over advance so a restart always begins exactly at the seed.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lfsr_a <= '0;
      lfsr_b <= '0;
    end else if (load_i) begin
      lfsr_a <= seed_i;
      lfsr_b <= seed_i;
    end else if (adv_i) begin
      lfsr_a <= lfsr_step(lfsr_a, TAPS_A);
      lfsr_b <= lfsr_step(lfsr_b, TAPS_B);
    end
  end

  assign gold_o = lfsr_a[4] ^ lfsr_b[4];

endmodule

// File: rtl/cdma_despreader.sv
// Gold-code despreader: correlates 31-chip symbols against a local code,
// acquires code phase by single-chip slips and tracks with a miss budget.
module cdma_despreader
  import cdma_pkg::*;
#(
  parameter int THRESH   = 28,
  parameter int MISS_MAX = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       chip_i,
  input  logic       chip_valid_i,
  input  logic [4:0] seed_i,
  input  logic       load_i,
  output logic       bit_o,
  output logic       bit_valid_o,
  output logic [4:0] agree_o,
  output logic       locked_o,
  output logic       slip_o,
  output logic       seed_err_o
);

  localparam logic [4:0] LAST_CHIP = 5'(SYM_LEN - 1);
  localparam logic [4:0] THRESH_C  = 5'(THRESH);
  localparam logic [7:0] MISS_C    = 8'(MISS_MAX);

  state_t     state, state_n;
  logic [4:0] chip_cnt;
  logic [4:0] ones;
  logic [7:0] miss_cnt;
  logic       slip_pend;
  logic       gold;

  logic       chip_en, take, do_slip, last, good, miss_hit;
  logic       emit_bit, arm_slip;
  logic [4:0] ones_total, agree_now;

  assign chip_en    = chip_valid_i && !load_i && (state != ST_IDLE);
  assign take       = chip_en && !slip_pend;
  assign do_slip    = chip_en && slip_pend;
  assign last       = take && (chip_cnt == LAST_CHIP);
  assign ones_total = ones + {4'd0, chip_i ^ gold};
  assign agree_now  = (ones_total >= 5'd16) ? ones_total : (5'd31 - ones_total);
  assign good       = (agree_now >= THRESH_C);
  assign miss_hit   = ((miss_cnt + 8'd1) >= MISS_C);

  gold_gen u_gold (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (load_i),
    .seed_i (seed_i),
    .adv_i  (take),
    .gold_o (gold)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (load_i) begin
      state_n = (seed_i != 5'd0) ? ST_ACQ : ST_IDLE;
    end else if (last) begin
      case (state)
        ST_ACQ:   if (good) state_n = ST_TRACK;
        ST_TRACK: if (!good && miss_hit) state_n = ST_ACQ;
        default:  state_n = state;
      endcase
    end
  end

  // A bad symbol in ACQ, or the last allowed miss in TRACK, re-arms a slip.
  always_comb begin
    locked_o = (state == ST_TRACK);
    emit_bit = last && ((state == ST_TRACK) || ((state == ST_ACQ) && good));
    arm_slip = last && !good && ((state == ST_ACQ) || ((state == ST_TRACK) && miss_hit));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      chip_cnt    <= '0;
      ones        <= '0;
      miss_cnt    <= '0;
      slip_pend   <= 1'b0;
      bit_o       <= 1'b0;
      bit_valid_o <= 1'b0;
      agree_o     <= '0;
      slip_o      <= 1'b0;
      seed_err_o  <= 1'b0;
    end else begin
      bit_valid_o <= emit_bit;
      slip_o      <= do_slip;
      if (load_i) begin
        chip_cnt   <= '0;
        ones       <= '0;
        miss_cnt   <= '0;
        slip_pend  <= 1'b0;
        seed_err_o <= (seed_i == 5'd0);
      end else begin
        if (do_slip) slip_pend <= 1'b0;
        if (take) begin
          if (last) begin
            chip_cnt <= '0;
            ones     <= '0;
            bit_o    <= (ones_total >= 5'd16);
            agree_o  <= agree_now;
            if (state != ST_TRACK || good || miss_hit) miss_cnt <= '0;
            else                                       miss_cnt <= miss_cnt + 8'd1;
            if (arm_slip) slip_pend <= 1'b1;
          end else begin
            chip_cnt <= chip_cnt + 5'd1;
            ones     <= ones_total;
          end
        end
      end
    end
  end

endmodule
